// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - front-panel bundle: observation pages, switches, button, display and step outputs
interface disp_scan_ctrl_if;
    logic [15:0] Page0;
    logic [15:0] Page1;
    logic [15:0] Page2;
    logic [15:0] Page3;
    logic [1:0]  Sel;
    logic        Btn;
    logic [3:0]  Out;
    logic [3:0]  Bit;
    logic [1:0]  CurSel;
    logic        Step;

    modport master (
        output Page0, Page1, Page2, Page3, Sel, Btn,
        input  Out, Bit, CurSel, Step
    );

    modport slave (
        input  Page0, Page1, Page2, Page3, Sel, Btn,
        output Out, Bit, CurSel, Step
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 4-digit display scanner with frame-latched page select and debounced step pulse
module disp_scan_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             Reset,
    disp_scan_ctrl_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    d;
    logic [15:0]   frame;
    logic [1:0]    cur_sel_q;
    logic [3:0]    out_q;
    logic [3:0]    bit_q;

    logic          sync1;
    logic          btn_s;
    logic          state;
    logic          state_q;
    logic [DW-1:0] deb_cnt;
    logic          step_q;

    logic          tick;
    logic [1:0]    d_next;
    logic          frame_start;
    logic [15:0]   page_sel;
    logic [15:0]   frame_next;
    logic [3:0]    nib_next;
    logic [3:0]    bit_next;

    assign tick        = (cnt == CW'(SCAN_DIV - 1));
    assign d_next      = d + 2'd1;
    assign frame_start = tick && (d_next == 2'd0);

    always_comb begin
        page_sel = bus.Page0;
        case (bus.Sel)
            2'd0: page_sel = bus.Page0;
            2'd1: page_sel = bus.Page1;
            2'd2: page_sel = bus.Page2;
            2'd3: page_sel = bus.Page3;
            default: page_sel = bus.Page0;
        endcase
    end

    // The digit lit after a frame-start edge must come from the new snapshot,
    // so the nibble is picked from the frame value valid after that edge.
    assign frame_next = frame_start ? page_sel : frame;

    always_comb begin
        nib_next = frame_next[3:0];
        bit_next = 4'b0111;
        case (d_next)
            2'd0: begin nib_next = frame_next[15:12]; bit_next = 4'b1110; end
            2'd1: begin nib_next = frame_next[11:8];  bit_next = 4'b1101; end
            2'd2: begin nib_next = frame_next[7:4];   bit_next = 4'b1011; end
            2'd3: begin nib_next = frame_next[3:0];   bit_next = 4'b0111; end
            default: begin nib_next = frame_next[3:0]; bit_next = 4'b0111; end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            cnt       <= '0;
            d         <= 2'd3;
            frame     <= '0;
            cur_sel_q <= '0;
            out_q     <= '0;
            bit_q     <= 4'b1111;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                d     <= d_next;
                out_q <= nib_next;
                bit_q <= bit_next;
                if (frame_start) begin
                    frame     <= page_sel;
                    cur_sel_q <= bus.Sel;
                end
            end
        end
    end

    // Any cycle where the synchronized level agrees with the accepted state
    // restarts qualification, so bounces shorter than DEB_CYCLES never toggle.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            sync1   <= 1'b0;
            btn_s   <= 1'b0;
            state   <= 1'b0;
            state_q <= 1'b0;
            deb_cnt <= '0;
            step_q  <= 1'b0;
        end else begin
            sync1   <= bus.Btn;
            btn_s   <= sync1;
            state_q <= state;
            step_q  <= state & ~state_q;
            if (btn_s != state) begin
                if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    state   <= ~state;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign bus.Out    = out_q;
    assign bus.Bit    = bit_q;
    assign bus.CurSel = cur_sel_q;
    assign bus.Step   = step_q;
endmodule
